// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES sequencer types and constants
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES128_ROUNDS   = 10;

    // Bit n is set where state byte n opens a new column (bytes 0, 4, 8, 12)
    localparam logic [15:0] COL_BOUNDARY_MASK = 16'h1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/aes_byte_round_counter.sv
// rtl/aes_byte_round_counter.sv - byte/round position counter shared by the AES sequencers
module aes_byte_round_counter
    import aes_pkg::*;
#(
    parameter int MAX_ROUND = AES128_ROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] byte_idx,
    output logic [3:0] round_idx,
    output logic       byte_tc,
    output logic       round_pre_last
);

    localparam logic [3:0] LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);
    localparam logic [3:0] MAX_R     = 4'(MAX_ROUND);

    assign byte_tc        = (byte_idx == LAST_BYTE);
    assign round_pre_last = (round_idx == MAX_R - 4'd1);

    // Byte position wraps every 16 steps; the round steps on that wrap and saturates at MAX_ROUND
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx  <= 4'd0;
            round_idx <= 4'd0;
        end else if (clr) begin
            byte_idx  <= 4'd0;
            round_idx <= 4'd0;
        end else if (inc) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_tc && (round_idx != MAX_R)) begin
                round_idx <= round_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - byte-serial AES-128 round controller (optional AES_SEQ_BACKPRESSURE_EN adds out_ready)
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int KEY_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
`ifdef AES_SEQ_BACKPRESSURE_EN
    input  logic                  out_ready,
`endif
    output logic                  in_ready,
    output logic                  bp_en,
    output logic                  mc_en,
    output logic                  mc_bypass,
    output logic                  pts_en,
    output logic [3:0]            round_idx,
    output logic [3:0]            byte_idx,
    output logic [KEY_ADDR_W-1:0] key_addr,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    seq_state_e state;
    seq_state_e state_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       byte_tc;
    logic       round_pre_last;
    logic       out_hold;

    aes_byte_round_counter #(
        .MAX_ROUND(NUM_ROUNDS)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (cnt_clr),
        .inc           (cnt_inc),
        .byte_idx      (byte_idx),
        .round_idx     (round_idx),
        .byte_tc       (byte_tc),
        .round_pre_last(round_pre_last)
    );

    // Round-key byte address is round*16 + byte, i.e. the two nibbles side by side
    assign key_addr = KEY_ADDR_W'({round_idx, byte_idx});

    // Datapath output register lags FINAL by one byte, so the 16th byte lands in DRAIN
    assign out_valid = ((state == ST_FINAL) && (byte_idx != 4'd0)) || (state == ST_DRAIN);
    assign out_last  = (state == ST_DRAIN);
    assign in_ready  = (state == ST_LOAD);
    assign mc_bypass = (state == ST_FINAL);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef AES_SEQ_BACKPRESSURE_EN
    assign out_hold = out_valid && !out_ready;
`else
    assign out_hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath enable decode
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bp_en     = 1'b0;
        mc_en     = 1'b0;
        pts_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    cnt_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    bp_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (byte_tc) begin
                        state_nxt = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                bp_en   = 1'b1;
                cnt_inc = 1'b1;
                mc_en   = !COL_BOUNDARY_MASK[byte_idx];
                pts_en  = byte_tc;
                if (byte_tc && round_pre_last) begin
                    state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (!out_hold) begin
                    bp_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (byte_tc) begin
                        state_nxt = ST_DRAIN;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_hold) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - randomized model-checked bench for aes_round_sequencer
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    localparam int NR        = 10;
    localparam int P_IDLE    = 0;
    localparam int P_RUN     = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DONE    = 3;
    localparam int LAST_STEP = 16 * NR + 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, bp_en, mc_en, mc_bypass, pts_en;
    logic       out_valid, out_last, busy, done;
    logic [3:0] round_idx, byte_idx;
    logic [7:0] key_addr;
`ifdef AES_SEQ_BACKPRESSURE_EN
    logic       out_ready = 1'b1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_phase = P_IDLE;
    int m_t = 0;
    int start_cyc = 0;
    int lat = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int rdy_cnt = 0;
    int byp_cnt = 0;
    logic [15:0] mc_pat = '0;
    logic [15:0] pts_pat = '0;
    logic [7:0]  ka_first = '0;
    logic [7:0]  ka_last = '0;

    aes_round_sequencer #(
        .NUM_ROUNDS(NR),
        .KEY_ADDR_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
`ifdef AES_SEQ_BACKPRESSURE_EN
        .out_ready(out_ready),
`endif
        .in_ready (in_ready),
        .bp_en    (bp_en),
        .mc_en    (mc_en),
        .mc_bypass(mc_bypass),
        .pts_en   (pts_en),
        .round_idx(round_idx),
        .byte_idx (byte_idx),
        .key_addr (key_addr),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a block is a count of datapath steps; step s belongs to round s/16, byte s%16
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= P_IDLE;
            m_t     <= 0;
        end else begin
            case (m_phase)
                P_IDLE:  if (start) begin m_phase <= P_RUN; m_t <= 0; end
                P_RUN: begin
                    if (m_t < 16) begin
                        if (in_valid) m_t <= m_t + 1;
                    end else if (m_t == LAST_STEP) begin
                        m_phase <= P_DRAIN;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                P_DRAIN: m_phase <= P_DONE;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        int r, b;
        logic e_rdy, e_bp, e_mc, e_byp, e_pts, e_ov, e_ol, e_busy, e_done;
        r = m_t / 16;
        b = m_t % 16;
        {e_rdy, e_bp, e_mc, e_byp, e_pts, e_ov, e_ol, e_busy, e_done} = '0;
        e_busy = (m_phase != P_IDLE);
        if (m_phase == P_RUN) begin
            if (r == 0) begin
                e_rdy = 1'b1;
                e_bp  = in_valid;
            end else if (r < NR) begin
                e_bp  = 1'b1;
                e_mc  = (b % 4) != 0;
                e_pts = (b == 15);
            end else begin
                e_bp  = 1'b1;
                e_byp = 1'b1;
                e_ov  = (b != 0);
            end
        end else if (m_phase == P_DRAIN) begin
            e_ov = 1'b1;
            e_ol = 1'b1;
        end else if (m_phase == P_DONE) begin
            e_done = 1'b1;
        end
        chk("ctl{rdy,bp,mc,byp,pts,ov,ol,busy,done}",
            {in_ready, bp_en, mc_en, mc_bypass, pts_en, out_valid, out_last, busy, done},
            {e_rdy, e_bp, e_mc, e_byp, e_pts, e_ov, e_ol, e_busy, e_done});
        if (m_phase == P_RUN)
            chk("idx{round,byte,key}", {round_idx, byte_idx, key_addr},
                {r[3:0], b[3:0], 8'(r * 16 + b)});

        if (rst && m_phase == P_IDLE && start) begin
            start_cyc = cyc;
            hs_cnt    = 0;
            rdy_cnt   = 0;
            byp_cnt   = 0;
        end
        if (out_valid) hs_cnt++;
        if (in_ready) rdy_cnt++;
        if (mc_bypass) byp_cnt++;
        if (done) begin
            lat = cyc - start_cyc + 1;
            done_cnt++;
        end
        if (m_phase == P_RUN && r == 1) begin
            mc_pat[b]  = mc_en;
            pts_pat[b] = pts_en;
            if (b == 0) ka_first = key_addr;
            if (b == 15) ka_last = key_addr;
        end
    end

    task automatic run_block(input int stall_len);
        int d0, n;
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (stall_len > 0) begin
            repeat (6) @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk("stall_byte_idx", byte_idx, 6);
            chk("stall_bp_en", bp_en, 0);
            repeat (stall_len) @(posedge clk);
            #1 in_valid = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {in_ready, bp_en, mc_en, mc_bypass, pts_en, out_valid, out_last, busy, done}, 0);
        chk("reset_key", key_addr, 0);
        chk("reset_idx", {round_idx, byte_idx}, 0);
        @(posedge clk); #1 rst = 1'b1;

        run_block(0);
        chk("lat_nominal", lat, 179);
        chk("out_beats", hs_cnt, 16);
        chk("in_ready_cycles", rdy_cnt, 16);
        chk("bypass_cycles", byp_cnt, 16);
        chk("mc_pattern_r1", mc_pat, 16'hEEEE);
        chk("pts_pattern_r1", pts_pat, 16'h8000);
        chk("key_first_r1", ka_first, 8'h10);
        chk("key_last_r1", ka_last, 8'h1F);

        run_block(3);
        chk("lat_stall", lat, 182);
        chk("out_beats_stall", hs_cnt, 16);

        repeat (1500) begin
            @(posedge clk); #1;
            in_valid = ($urandom % 4) != 0;
            start    = ($urandom % 16) == 0;
        end
        start = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_after_random", busy, 0);

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(m_phase == P_RUN && m_t == 4 * 16 + 7) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_round4", round_idx, 4);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_ctl", {in_ready, bp_en, mc_en, mc_bypass, pts_en, out_valid, out_last, busy, done}, 0);
        chk("async_reset_key", key_addr, 0);
        n = done_cnt;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        chk("no_done_after_reset", done_cnt, n);

        run_block(0);
        chk("lat_after_reset", lat, 179);
        chk("out_beats_after_reset", hs_cnt, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Top-level controller for the byte-serial AES-128 encryption datapath: byte permutation, then sub_bytes, then mix_col, then pts_converter.
- Accepts one 16-byte block over a valid/ready byte stream.
- Sequences NUM_ROUNDS rounds of 16 byte-cycles each, generating the datapath enables, round index and round-key byte address.
- Streams the 16 ciphertext bytes out with valid/last. Replaces the free-running counter and ad-hoc enable decode around the round datapath.

Parameters:
- NUM_ROUNDS, 10, number of rounds. Legal range 2..15. The final round bypasses mix_col.
- KEY_ADDR_W, 8, width of the round-key byte address. Must be ≥ 4 + clog2(NUM_ROUNDS+1).

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-low reset.
- start  in  1  Begin a new block. Sampled only in IDLE.
- in_valid  in  1  Plaintext byte valid.
- in_ready  out  1  Sequencer accepts a plaintext byte.
- bp_en  out  1  Byte-permutation load/shift enable.
- mc_en  out  1  mix_col column-accumulate enable.
- mc_bypass  out  1  Final round: route sub_bytes output around mix_col.
- pts_en  out  1  pts_converter column load.
- round_idx  out  4  Current round, 0 = initial AddRoundKey/load.
- byte_idx  out  4  Byte position within the current state.
- key_addr  out  KEY_ADDR_W  Round-key byte address = round_idx*16 + byte_idx.
- out_valid  out  1  Ciphertext byte valid on the datapath output.
- out_last  out  1  Asserted with the 16th ciphertext byte.
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse after the last output byte.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except key_addr=0. byte_idx and round_idx are cleared.
- States: IDLE, LOAD, ROUND, FINAL, DRAIN, DONE.
- IDLE:
  - start=1 → LOAD next cycle, round_idx=0, byte_idx=0.
  - start during any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1: bp_en=1 and byte_idx increments. in_valid=0 stalls; byte_idx and all enables hold or stay low.
  - Acceptance of byte 15 → ROUND with round_idx=1, byte_idx=0.
- ROUND (round_idx 1..NUM_ROUNDS-1): unstallable, 16 cycles per round.
  - bp_en=1 every cycle.
  - mc_en=1 when byte_idx[1:0]≠0; mc_en=0 at byte_idx 0, 4, 8, 12 (column boundary).
  - pts_en=1 at byte_idx=15 only.
  - byte_idx wraps 15→0 and round_idx increments at the wrap.
  - After round NUM_ROUNDS-1 wraps → FINAL.
- FINAL (round_idx=NUM_ROUNDS): 16 cycles.
  - bp_en=1, mc_bypass=1, mc_en=0, pts_en=0.
  - Output bytes are produced directly from sub_bytes.
  - Then → DRAIN.
- Output timing: out_valid=1 for exactly 16 consecutive cycles, starting 1 cycle after FINAL entry (datapath register latency 1). out_last=1 on the 16th.
- DRAIN: covers the last output byte. → DONE.
- DONE: done=1 for one cycle. → IDLE. busy drops in the same cycle IDLE is entered.
- key_addr is combinational from round_idx and byte_idx. It is valid in LOAD, ROUND and FINAL.
- Total latency, start to done (no LOAD stalls): 1 + 16 + 16*(NUM_ROUNDS-1) + 16 + 1 + 1 cycles = 179 for NUM_ROUNDS=10.
- Reset mid-operation: immediate return to IDLE. No done pulse; partial output is discarded.
- Counter widths: 4-bit byte_idx and round_idx. round_idx never exceeds NUM_ROUNDS.

Optional Feature:
- AES_SEQ_BACKPRESSURE_EN:
  - When defined: adds input port out_ready (1 bit).
  - In FINAL/DRAIN, a cycle with out_valid=1 and out_ready=0 freezes byte_idx, bp_en, out_valid and out_last, and the state holds.
  - The out_valid/out_last pair must remain stable until accepted.
- When undefined: no out_ready port; output is streamed unconditionally, as specified above.

Decomposition:
- Shared package aes_pkg:
  - state enum.
  - AES_BLOCK_BYTES=16 and AES128_ROUNDS=10.
  - Column-boundary mask constant.
- One natural sub-module: aes_byte_round_counter. Holds byte_idx/round_idx with enable, wrap and terminal-count outputs, and is reusable by the decrypt sequencer.
- The FSM and enable decode stay in aes_round_sequencer.

Test Plan:
- Reset, then start with in_valid held 1 and bytes 0x00..0x0F:
  - in_ready high for 16 cycles, then low.
  - bp_en high 16 cycles in LOAD.
  - done pulses at cycle 179 after start.
- During round 1: mc_en pattern across byte_idx 0..15 = 0,1,1,1,0,1,1,1,0,1,1,1,0,1,1,1. pts_en only at byte_idx 15. key_addr runs 0x10..0x1F.
- Round 10: mc_bypass=1 for 16 cycles. out_valid 16 cycles with out_last on the 16th. Using the FIPS-197 vector (key 000102..0F, pt 00112233..FF), the datapath output equals 69c4e0d8..c55a.
- LOAD stall: in_valid deasserted after byte 5 for 3 cycles. byte_idx holds at 6 and bp_en=0, and the total latency grows by exactly 3.
- Assert rst=0 mid-round 4: outputs go to 0 asynchronously, busy=0, no done pulse. A new start then completes normally.
- With AES_SEQ_BACKPRESSURE_EN: out_ready=0 for 2 cycles at output byte 7. out_valid stays high and byte_idx stays at 7. Exactly 16 handshakes occur and done is delayed by 2 cycles.
